// File: rtl/recv_move_input.sv
// Move entry over a UART: prompt '?', take a column and a row digit, claim the cell or retry/report an error.
// Latency: the row byte's sampling edge to valid is 2 edges (3 plus the uart_ready wait when RECV_MOVE_ECHO_EN echoes digits).
// Backpressure: prompt/echo strobes wait on uart_ready; req is ignored while busy; RECV_MOVE_ECHO_EN enables digit echo.
module recv_move_input #(
  parameter int ROWS      = 3,
  parameter int COLS      = 3,
  parameter int PLAYERS   = 2,
  parameter int MAX_RETRY = 2,
  parameter int TIMEOUT   = 0,
  localparam int CELLS    = ROWS * COLS,
  localparam int PW       = (PLAYERS > 2) ? $clog2(PLAYERS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req,
  input  logic [PW-1:0]            player,
  input  logic [PLAYERS*CELLS-1:0] board_in,
  output logic [PLAYERS*CELLS-1:0] board_out,
  output logic                     ready,
  output logic                     valid,
  output logic                     error_flag,
  output logic [1:0]               err_code,
  input  logic                     uart_rd,
  input  logic [7:0]               uart_q,
  output logic                     uart_wr,
  output logic [7:0]               uart_d,
  input  logic                     uart_ready
);

  localparam int CW = $clog2(COLS) + 1;
  localparam int RW = $clog2(ROWS) + 1;
  localparam int IW = $clog2(CELLS) + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE, PROMPT, RECV_COL, RECV_ROW, CHECK, EMIT
`ifdef RECV_MOVE_ECHO_EN
    , ECHO
`endif
  } state_t;

  state_t                   state, state_nxt;
  logic                     busy;
  logic [PW-1:0]            player_q;
  logic [PLAYERS*CELLS-1:0] board_q, board_set;
  logic [CW-1:0]            col;
  logic [RW-1:0]            row;
  logic [IW-1:0]            idx;
  logic [3:0]               retry_cnt;
  logic [TW-1:0]            tmo_cnt;
  logic [7:0]               digit;
  logic                     col_char_ok, row_char_ok, in_recv, tmo_hit, occupied;
  logic                     start, send_prompt, col_ok, row_ok, fail, retry, emit_ok, tmo_fire;
  logic [1:0]               fail_code;
`ifdef RECV_MOVE_ECHO_EN
  logic                     echo_row, echo_send;
`endif

  assign ready       = !req && !busy;
  assign digit       = uart_q - 8'h30;
  assign col_char_ok = (uart_q >= 8'h30) && (digit < 8'(COLS));
  assign row_char_ok = (uart_q >= 8'h30) && (digit < 8'(ROWS));
  assign in_recv     = (state == RECV_COL) || (state == RECV_ROW);
  assign tmo_hit     = (TIMEOUT > 0) && (tmo_cnt == TW'(TIMEOUT - 1));

  // Cell is free only if no plane claims it; the claim goes into the latched player's plane.
  always_comb begin
    occupied  = 1'b0;
    board_set = board_q;
    for (int p = 0; p < PLAYERS; p++) begin
      if (board_q[p*CELLS + int'(idx)]) occupied = 1'b1;
      if (PW'(p) == player_q) board_set[p*CELLS + int'(idx)] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start       = 1'b0;
    send_prompt = 1'b0;
    col_ok      = 1'b0;
    row_ok      = 1'b0;
    fail        = 1'b0;
    fail_code   = 2'd0;
    emit_ok     = 1'b0;
    tmo_fire    = 1'b0;
`ifdef RECV_MOVE_ECHO_EN
    echo_send   = 1'b0;
`endif
    case (state)
      IDLE: if (req) begin
        start     = 1'b1;
        state_nxt = PROMPT;
      end
      PROMPT: if (uart_ready) begin
        send_prompt = 1'b1;
        state_nxt   = RECV_COL;
      end
      RECV_COL: begin
        // A byte in the expiry cycle wins over the timeout.
        if (uart_rd) begin
          if (col_char_ok) begin
            col_ok = 1'b1;
`ifdef RECV_MOVE_ECHO_EN
            state_nxt = ECHO;
`else
            state_nxt = RECV_ROW;
`endif
          end else begin
            fail      = 1'b1;
            fail_code = 2'd1;
          end
        end else if (tmo_hit) begin
          tmo_fire  = 1'b1;
          state_nxt = IDLE;
        end
      end
      RECV_ROW: begin
        if (uart_rd) begin
          if (row_char_ok) begin
            row_ok = 1'b1;
`ifdef RECV_MOVE_ECHO_EN
            state_nxt = ECHO;
`else
            state_nxt = CHECK;
`endif
          end else begin
            fail      = 1'b1;
            fail_code = 2'd1;
          end
        end else if (tmo_hit) begin
          tmo_fire  = 1'b1;
          state_nxt = IDLE;
        end
      end
      CHECK: state_nxt = EMIT;
      EMIT: begin
        if (!occupied) begin
          emit_ok   = 1'b1;
          state_nxt = IDLE;
        end else begin
          fail      = 1'b1;
          fail_code = 2'd2;
        end
      end
`ifdef RECV_MOVE_ECHO_EN
      ECHO: if (uart_ready) begin
        echo_send = 1'b1;
        state_nxt = echo_row ? CHECK : RECV_ROW;
      end
`endif
      default: state_nxt = IDLE;
    endcase
    retry = fail && (retry_cnt < 4'(MAX_RETRY));
    if (fail) state_nxt = retry ? PROMPT : IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy       <= 1'b1;
      valid      <= 1'b0;
      error_flag <= 1'b0;
      err_code   <= 2'd0;
      uart_wr    <= 1'b0;
      uart_d     <= 8'd0;
      retry_cnt  <= 4'd0;
      tmo_cnt    <= '0;
      board_out  <= '0;
      board_q    <= '0;
      player_q   <= '0;
      col        <= '0;
      row        <= '0;
      idx        <= '0;
`ifdef RECV_MOVE_ECHO_EN
      echo_row   <= 1'b0;
`endif
    end else begin
      valid   <= 1'b0;
      uart_wr <= 1'b0;
      tmo_cnt <= (in_recv && !uart_rd) ? tmo_cnt + 1'b1 : '0;
      if (state == IDLE && !req) busy <= 1'b0;
      if (start) begin
        player_q   <= player;
        board_q    <= board_in;
        retry_cnt  <= 4'd0;
        error_flag <= 1'b0;
        err_code   <= 2'd0;
        busy       <= 1'b1;
      end
      if (send_prompt) begin
        uart_wr <= 1'b1;
        uart_d  <= 8'h3F;
      end
      if (col_ok) col <= CW'(digit);
      if (row_ok) row <= RW'(digit);
`ifdef RECV_MOVE_ECHO_EN
      if (col_ok) echo_row <= 1'b0;
      if (row_ok) echo_row <= 1'b1;
      if (echo_send) begin
        uart_wr <= 1'b1;
        uart_d  <= echo_row ? 8'h30 + 8'(row) : 8'h30 + 8'(col);
      end
`endif
      if (state == CHECK) idx <= IW'(row) * IW'(COLS) + IW'(col);
      if (emit_ok) begin
        board_out <= board_set;
        err_code  <= 2'd0;
        valid     <= 1'b1;
        busy      <= 1'b0;
      end
      if (fail) begin
        if (retry) begin
          retry_cnt <= retry_cnt + 4'd1;
        end else begin
          error_flag <= 1'b1;
          err_code   <= fail_code;
          valid      <= 1'b1;
          busy       <= 1'b0;
        end
      end
      if (tmo_fire) begin
        error_flag <= 1'b1;
        err_code   <= 2'd3;
        valid      <= 1'b1;
        busy       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_recv_move_input.sv
// Directed bench: a 3x3 instance with a 100-cycle timeout and a 4x10 instance with no retries.
module tb_recv_move_input;

`ifdef RECV_MOVE_ECHO_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_a, req_b;
  logic [0:0]  player;
  logic [17:0] board_in_a, board_out_a;
  logic [79:0] board_in_b, board_out_b;
  logic        ready_a, valid_a, errf_a, wr_a;
  logic        ready_b, valid_b, errf_b, wr_b;
  logic [1:0]  code_a, code_b;
  logic [7:0]  d_a, d_b;
  logic        uart_rd, uart_ready;
  logic [7:0]  uart_q;

  int checks = 0;
  int errors = 0;
  int pr_a = 0, vc_a = 0, pr_b = 0, vc_b = 0, ec_b = 0;
  logic [7:0] eb [0:7];

  recv_move_input #(.ROWS(3), .COLS(3), .PLAYERS(2), .MAX_RETRY(2), .TIMEOUT(100)) u_a (
    .clk(clk), .reset(reset), .req(req_a), .player(player), .board_in(board_in_a),
    .board_out(board_out_a), .ready(ready_a), .valid(valid_a), .error_flag(errf_a),
    .err_code(code_a), .uart_rd(uart_rd), .uart_q(uart_q), .uart_wr(wr_a), .uart_d(d_a),
    .uart_ready(uart_ready));

  recv_move_input #(.ROWS(4), .COLS(10), .PLAYERS(2), .MAX_RETRY(0), .TIMEOUT(0)) u_b (
    .clk(clk), .reset(reset), .req(req_b), .player(player), .board_in(board_in_b),
    .board_out(board_out_b), .ready(ready_b), .valid(valid_b), .error_flag(errf_b),
    .err_code(code_b), .uart_rd(uart_rd), .uart_q(uart_q), .uart_wr(wr_b), .uart_d(d_b),
    .uart_ready(uart_ready));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_a && d_a == 8'h3F) pr_a++;
    if (valid_a) vc_a++;
    if (wr_b) begin
      if (d_b == 8'h3F) pr_b++;
      else begin
        if (ec_b < 8) eb[ec_b] = d_b;
        ec_b++;
      end
    end
    if (valid_b) vc_b++;
  end

  task automatic start_a(input logic p, input logic [17:0] b);
    req_a = 1'b1; player = p; board_in_a = b;
    @(negedge clk);
    req_a = 1'b0;
  endtask

  task automatic start_b(input logic p, input logic [79:0] b);
    req_b = 1'b1; player = p; board_in_b = b;
    @(negedge clk);
    req_b = 1'b0;
  endtask

  task automatic wait_prompt(input bit sel_b);
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      seen = sel_b ? (wr_b && d_b == 8'h3F) : (wr_a && d_a == 8'h3F);
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL prompt_wait got none want '?' strobe"); end
  endtask

  task automatic wait_valid(input bit sel_b, output int n);
    n = 0;
    while (!(sel_b ? valid_b : valid_a) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 300) begin errors++; $display("FAIL valid_wait got none want valid pulse"); end
  endtask

  task automatic send_byte(input logic [7:0] b);
    uart_rd = 1'b1; uart_q = b;
    @(negedge clk);
    uart_rd = 1'b0;
  endtask

  task automatic send_digit(input logic [7:0] b);
    send_byte(b);
`ifdef RECV_MOVE_ECHO_EN
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
        @(negedge clk);
        seen = (wr_a || wr_b) && (wr_a ? d_a : d_b) == b;
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL echo_wait got none want %0h", b); end
    end
`endif
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", valid_a); end
    checks++; if (errf_a !== 1'b0) begin errors++; $display("FAIL rst_errf got %b want 0", errf_a); end
    checks++; if (code_a !== 2'd0) begin errors++; $display("FAIL rst_code got %0d want 0", code_a); end
    checks++; if (wr_a !== 1'b0 || d_a !== 8'h00) begin errors++; $display("FAIL rst_uart got %b/%0h want 0/0", wr_a, d_a); end
    checks++; if (board_out_a !== 18'h0 || board_out_b !== 80'h0) begin errors++; $display("FAIL rst_board got %0h want 0", board_out_a); end
    checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", ready_a); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (ready_a !== 1'b1 || ready_b !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b%b want 11", ready_a, ready_b); end
  endtask

  task automatic test_basic();
    int p0 = pr_a, v0 = vc_a, n;
    start_a(1'b1, 18'h0);
    checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL basic_busy_ready got %b want 0", ready_a); end
    wait_prompt(0);
    // req pulse with different player/board while busy must be ignored
    req_a = 1'b1; player = 1'b0; board_in_a = 18'h3FFFF;
    send_digit("2");
    req_a = 1'b0; board_in_a = 18'h0;
    send_byte("1");
    wait_valid(0, n);
    checks++; if (n !== LAT) begin errors++; $display("FAIL basic_latency got %0d want %0d", n, LAT); end
    checks++; if (code_a !== 2'd0 || errf_a !== 1'b0) begin errors++; $display("FAIL basic_code got %0d/%b want 0/0", code_a, errf_a); end
    checks++; if (board_out_a !== 18'h04000) begin errors++; $display("FAIL basic_board got %0h want 4000", board_out_a); end
    @(negedge clk);
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL basic_pulse got %b want 0", valid_a); end
    checks++; if (pr_a - p0 !== 1 || vc_a - v0 !== 1) begin errors++; $display("FAIL basic_counts got %0d/%0d want 1/1", pr_a - p0, vc_a - v0); end
    checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL basic_ready got %b want 1", ready_a); end
  endtask

  task automatic test_retry();
    int p0 = pr_a, v0 = vc_a, n;
    start_a(1'b0, 18'h0);
    wait_prompt(0);
    send_byte("x");
    wait_prompt(0);
    send_digit("0");
    send_digit("0");
    wait_valid(0, n);
    checks++; if (code_a !== 2'd0 || errf_a !== 1'b0) begin errors++; $display("FAIL retry_code got %0d/%b want 0/0", code_a, errf_a); end
    checks++; if (board_out_a !== 18'h00001) begin errors++; $display("FAIL retry_board got %0h want 1", board_out_a); end
    @(negedge clk);
    checks++; if (pr_a - p0 !== 2 || vc_a - v0 !== 1) begin errors++; $display("FAIL retry_counts got %0d/%0d want 2/1", pr_a - p0, vc_a - v0); end
  endtask

  task automatic test_occupied();
    int p0 = pr_a, v0 = vc_a, n;
    start_a(1'b1, 18'h00010);
    for (int k = 0; k < 3; k++) begin
      wait_prompt(0);
      send_digit("1");
      send_digit("1");
    end
    wait_valid(0, n);
    checks++; if (code_a !== 2'd2 || errf_a !== 1'b1) begin errors++; $display("FAIL occ_code got %0d/%b want 2/1", code_a, errf_a); end
    checks++; if (board_out_a !== 18'h00001) begin errors++; $display("FAIL occ_board got %0h want 1", board_out_a); end
    @(negedge clk);
    checks++; if (pr_a - p0 !== 3 || vc_a - v0 !== 1) begin errors++; $display("FAIL occ_counts got %0d/%0d want 3/1", pr_a - p0, vc_a - v0); end
  endtask

  task automatic test_timeout();
    int p0 = pr_a, v0 = vc_a, n;
    start_a(1'b0, 18'h0);
    wait_prompt(0);
    wait_valid(0, n);
    checks++; if (n !== 100) begin errors++; $display("FAIL tmo_cycles got %0d want 100", n); end
    checks++; if (code_a !== 2'd3 || errf_a !== 1'b1) begin errors++; $display("FAIL tmo_code got %0d/%b want 3/1", code_a, errf_a); end
    checks++; if (board_out_a !== 18'h00001) begin errors++; $display("FAIL tmo_board got %0h want 1", board_out_a); end
    @(negedge clk);
    checks++; if (pr_a - p0 !== 1 || vc_a - v0 !== 1) begin errors++; $display("FAIL tmo_counts got %0d/%0d want 1/1", pr_a - p0, vc_a - v0); end
  endtask

  task automatic test_tmo_race();
    int p0 = pr_a, n;
    start_a(1'b0, 18'h0);
    uart_ready = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (pr_a - p0 !== 0 || wr_a !== 1'b0) begin errors++; $display("FAIL stall_prompt got %0d want 0", pr_a - p0); end
    uart_ready = 1'b1;
    wait_prompt(0);
    repeat (99) @(negedge clk);
    send_digit("1");
    send_digit("2");
    wait_valid(0, n);
    checks++; if (code_a !== 2'd0 || errf_a !== 1'b0) begin errors++; $display("FAIL race_code got %0d/%b want 0/0", code_a, errf_a); end
    checks++; if (board_out_a !== 18'h00080) begin errors++; $display("FAIL race_board got %0h want 80", board_out_a); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int v0, n;
    start_a(1'b1, 18'h0);
    wait_prompt(0);
    send_digit("0");
    v0 = vc_a;
    reset = 1'b0;
    #1;
    checks++; if (board_out_a !== 18'h0) begin errors++; $display("FAIL mid_rst_board got %0h want 0", board_out_a); end
    checks++; if (valid_a !== 1'b0 || wr_a !== 1'b0 || ready_a !== 1'b0) begin errors++; $display("FAIL mid_rst_outs got %b%b%b want 000", valid_a, wr_a, ready_a); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    start_a(1'b1, 18'h0);
    wait_prompt(0);
    send_digit("0");
    send_digit("2");
    wait_valid(0, n);
    checks++; if (board_out_a !== 18'h08000 || code_a !== 2'd0) begin errors++; $display("FAIL mid_next_board got %0h/%0d want 8000/0", board_out_a, code_a); end
    @(negedge clk);
    checks++; if (vc_a - v0 !== 1) begin errors++; $display("FAIL mid_valid_count got %0d want 1", vc_a - v0); end
  endtask

  task automatic test_wide();
    logic [79:0] exp_b = '0;
    int p0, n;
    checks++; if (vc_b !== 0 || pr_b !== 0 || board_out_b !== 80'h0) begin errors++; $display("FAIL wide_idle_ignored got %0d/%0d want 0/0", vc_b, pr_b); end
    exp_b[39] = 1'b1;
    start_b(1'b0, 80'h0);
    wait_prompt(1);
    send_digit("9");
    send_digit("3");
    wait_valid(1, n);
    checks++; if (board_out_b !== exp_b || code_b !== 2'd0) begin errors++; $display("FAIL wide_board got %0h/%0d want %0h/0", board_out_b, code_b, exp_b); end
    @(negedge clk);
`ifdef RECV_MOVE_ECHO_EN
    checks++; if (ec_b !== 2 || eb[0] !== 8'h39 || eb[1] !== 8'h33) begin errors++; $display("FAIL wide_echo got %0d bytes want 2 ('9','3')", ec_b); end
`else
    checks++; if (ec_b !== 0) begin errors++; $display("FAIL wide_echo got %0d bytes want 0", ec_b); end
`endif
    p0 = pr_b;
    start_b(1'b1, 80'h0);
    wait_prompt(1);
    send_digit("9");
    send_byte("4");
    wait_valid(1, n);
    checks++; if (code_b !== 2'd1 || errf_b !== 1'b1) begin errors++; $display("FAIL wide_badrow got %0d/%b want 1/1", code_b, errf_b); end
    checks++; if (board_out_b !== exp_b) begin errors++; $display("FAIL wide_hold got %0h want %0h", board_out_b, exp_b); end
    @(negedge clk);
    checks++; if (pr_b - p0 !== 1) begin errors++; $display("FAIL wide_noretry got %0d want 1", pr_b - p0); end
  endtask

  initial begin
    req_a = 1'b0; req_b = 1'b0; player = 1'b0;
    board_in_a = '0; board_in_b = '0;
    uart_rd = 1'b0; uart_q = 8'h00; uart_ready = 1'b1;
    test_reset();
    test_basic();
    test_retry();
    test_occupied();
    test_timeout();
    test_tmo_race();
    test_reset_mid();
    test_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/recv_move_input.md
RECV_MOVE_INPUT -- requirements
Module: recv_move_input

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- ROWS, 3, board rows, legal range 1..10
- COLS, 3, board columns, legal range 1..10
- PLAYERS, 2, number of board planes, legal range 2..8
- MAX_RETRY, 2, re-prompts allowed after a recoverable error, legal range 0..15
- TIMEOUT, 0, cycles to wait for each received character; 0 disables the timeout
REQ-002 The block SHALL define the derived constants CELLS=ROWS*COLS and PW=max(1,$clog2(PLAYERS)).
REQ-003 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1, the single clock
- reset, in, 1, asynchronous active-low reset (0 = reset)
- req, in, 1, start request
- player, in, PW, index of the player making the move
- board_in, in, PLAYERS*CELLS, board planes; plane p occupies bits [p*CELLS +: CELLS]
- board_out, out, PLAYERS*CELLS, registered board after the move
- ready, out, 1, equals !req && !busy
- valid, out, 1, one-cycle pulse marking a final result
- error_flag, out, 1, the result is an error
- err_code, out, 2, 0=ok, 1=bad char, 2=occupied, 3=timeout
- uart_rd, in, 1, received byte strobe
- uart_q, in, 8, received byte
- uart_wr, out, 1, one-cycle transmit strobe
- uart_d, out, 8, transmit byte
- uart_ready, in, 1, transmitter can accept a byte

Function
REQ-004 The FSM SHALL have the states IDLE, PROMPT, RECV_COL, RECV_ROW, ECHO, CHECK and EMIT.
REQ-005 In IDLE with req=1, the block SHALL latch player, board_in, clear retry_cnt, error_flag and err_code, set busy and go to PROMPT; otherwise it SHALL hold busy=0.
REQ-006 In PROMPT, when uart_ready=1, the block SHALL pulse uart_wr for one cycle with uart_d=8'h3F ('?') and go to RECV_COL.
REQ-007 In RECV_COL, a uart_rd byte in '0'..'0'+COLS-1 SHALL be stored as col (width $clog2(COLS)+1); any other byte SHALL be a bad-char error.
REQ-008 In RECV_ROW, a uart_rd byte in '0'..'0'+ROWS-1 SHALL be stored as row; any other byte SHALL be a bad-char error.
REQ-009 CHECK SHALL compute the index row*COLS+col into an unsigned register of width $clog2(CELLS)+1 in one cycle.
REQ-010 In EMIT, if no plane has the indexed bit set, the block SHALL set that bit in plane `player`, drive err_code=0 and pulse valid; otherwise it SHALL raise an occupied error.
REQ-011 On a bad-char or occupied error with retry_cnt<MAX_RETRY, the block SHALL increment retry_cnt and return to PROMPT without pulsing valid.
REQ-012 On a bad-char or occupied error with retry_cnt==MAX_RETRY, the block SHALL set error_flag=1 and the err_code, pulse valid and return to IDLE.
REQ-013 When TIMEOUT>0, a cycle counter SHALL be cleared on entry to RECV_COL or RECV_ROW and on every uart_rd in those states.
REQ-014 When the timeout counter reaches TIMEOUT-1, the block SHALL finish with err_code=3, error_flag=1 and a valid pulse, with no retry.
REQ-015 A uart_rd arriving in the same cycle the timeout expires SHALL take precedence over the timeout.
REQ-016 uart_rd SHALL be ignored in IDLE, PROMPT, ECHO, CHECK and EMIT.
REQ-017 A req asserted while busy SHALL be ignored.
REQ-018 board_out SHALL update only on a successful EMIT and otherwise hold the last latched value.
REQ-019 The total latency from the row byte to valid SHALL be exactly 2 cycles when echo is disabled.

Reset
REQ-020 While reset=0, the block SHALL asynchronously force state=IDLE, busy=1, valid=0, error_flag=0, err_code=0, uart_wr=0, uart_d=0, retry_cnt=0, the timeout counter to 0 and board_out=0.
REQ-021 The first IDLE cycle after reset release SHALL clear busy.
REQ-022 A reset assertion mid-transaction SHALL abort the transaction with no valid pulse.

Configuration
REQ-023 When the macro RECV_MOVE_ECHO_EN is defined, each accepted digit SHALL be echoed: the FSM enters ECHO, waits for uart_ready, pulses uart_wr with the digit, then continues to RECV_ROW or CHECK.
REQ-024 When RECV_MOVE_ECHO_EN is defined, the latency from an accepted row digit to valid SHALL be the uart_ready wait plus 3 cycles.
REQ-025 When RECV_MOVE_ECHO_EN is undefined, the ECHO state and its logic SHALL be absent and no echo bytes SHALL be sent.

Verification
REQ-026 3x3 board, empty, player=1, bytes '2','1' -> one '?' sent, plane1 bit5 set, valid=1, err_code=0.
REQ-027 Bytes 'x', then '0','0' with MAX_RETRY=2 -> two '?' sent, cell 0 set, a single valid with err_code=0.
REQ-028 Cell 4 occupied by plane0, input '1','1' three times with MAX_RETRY=2 -> three '?' sent, valid with err_code=2, board unchanged.
REQ-029 TIMEOUT=100 and no input -> valid at cycle 100 after the '?' strobe, err_code=3.
REQ-030 ROWS=4, COLS=10, bytes '9','3' -> bit 39 set; with RECV_MOVE_ECHO_EN defined, '9' and '3' are echoed after '?'.
REQ-031 Reset asserted in RECV_ROW -> outputs return to their reset values immediately; next req behaves normally.
